// File: rtl/pool_engine_if.sv
// Bus bundle for pool_engine: run handshake plus the parameter, input and output SRAM ports.
// The master modport is the engine side and the slave modport is the SRAM/controller side.
interface pool_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
);
    logic              start;
    logic              finish;
    logic              error;
    logic              param_cs;
    logic [ADDR_W-1:0] param_addr;
    logic [31:0]       param_rdata;
    logic              in_cs;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_rdata;
    logic              out_cs;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_wdata;

    modport master (
        input  start, param_rdata, in_rdata,
        output finish, error, param_cs, param_addr, in_cs, in_addr,
               out_cs, out_we, out_addr, out_wdata
    );

    modport slave (
        output start, param_rdata, in_rdata,
        input  finish, error, param_cs, param_addr, in_cs, in_addr,
               out_cs, out_we, out_addr, out_wdata
    );
endinterface

// File: rtl/pool_engine.sv
// Square max/avg pooling engine: loads a 5-word layer config, then for each output
// reads a KxK window from the input SRAM, reduces it and writes one element.
module pool_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32,
    parameter int MAX_K  = 4
) (
    input logic           clk,
    input logic           rstn,
    pool_engine_if.master bus
);
    localparam int DIM_W = 16;
    localparam int KW    = 8;
    localparam int EW    = DIM_W + 2;
    localparam int ACC_W = DATA_W + 2 * $clog2(MAX_K);
    localparam logic signed [ACC_W-1:0] MOST_NEG =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, READ, WRITE, DONE} state_e;

    state_e                    state_q, state_d;
    logic [2:0]                ld_cnt_q, ld_cnt_d;
    logic [DIM_W-1:0]          r_q, r_d, c_q, c_d;
    logic [KW-1:0]             k_q, k_d, s_q, s_d;
    logic                      m_q, m_d;
    logic [ADDR_W-1:0]         plane_q, plane_d;
    logic [2*KW-1:0]           kk_q, kk_d, rd_cnt_q, rd_cnt_d;
    logic [DIM_W-1:0]          ch_q, ch_d, row0_q, row0_d, col0_q, col0_d;
    logic [KW-1:0]             kr_q, kr_d, kc_q, kc_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]         out_idx_q, out_idx_d;
    logic                      finish_q, finish_d, error_q, error_d;

    logic                      param_cs_c, in_cs_c, out_we_c;
    logic                      cfg_bad, col_wrap, row_wrap;
    logic [2:0]                shift;
    logic signed [ACC_W-1:0]   in_sext;
    logic                      unused_bits;

    assign unused_bits = ^bus.param_rdata[31:DIM_W];
    assign in_sext     = ACC_W'($signed(bus.in_rdata));

    assign cfg_bad = (k_q == '0) || (k_q > KW'(MAX_K)) || (s_q == '0) ||
                     (DIM_W'(k_q) > r_q) || (c_q == '0) ||
                     (m_q && !(k_q == KW'(1) || k_q == KW'(2) || k_q == KW'(4)));

    // A window step wraps when the next window would run past the right/bottom edge.
    assign col_wrap = (EW'(col0_q) + EW'(s_q) + EW'(k_q)) > EW'(r_q);
    assign row_wrap = (EW'(row0_q) + EW'(s_q) + EW'(k_q)) > EW'(r_q);

    always_comb begin
        case (k_q)
            KW'(2):  shift = 3'd2;
            KW'(4):  shift = 3'd4;
            default: shift = 3'd0;
        endcase
    end

    assign bus.param_cs   = param_cs_c;
    assign bus.param_addr = ADDR_W'(ld_cnt_q);
    assign bus.in_cs      = in_cs_c;
    assign bus.in_addr    = ADDR_W'(ch_q) * plane_q
                          + (ADDR_W'(row0_q) + ADDR_W'(kr_q)) * ADDR_W'(r_q)
                          + ADDR_W'(col0_q) + ADDR_W'(kc_q);
    assign bus.out_cs     = out_we_c;
    assign bus.out_we     = out_we_c;
    assign bus.out_addr   = out_idx_q;
    assign bus.out_wdata  = m_q ? DATA_W'(acc_q >>> shift) : acc_q[DATA_W-1:0];
    assign bus.finish     = finish_q;
    assign bus.error      = error_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        s_d        = s_q;
        m_d        = m_q;
        plane_d    = plane_q;
        kk_d       = kk_q;
        rd_cnt_d   = rd_cnt_q;
        ch_d       = ch_q;
        row0_d     = row0_q;
        col0_d     = col0_q;
        kr_d       = kr_q;
        kc_d       = kc_q;
        acc_d      = acc_q;
        out_idx_d  = out_idx_q;
        error_d    = error_q;
        param_cs_c = 1'b0;
        in_cs_c    = 1'b0;
        out_we_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = LOAD;
                    ld_cnt_d = '0;
                end
            end
            LOAD: begin
                // Words are requested on counts 0..4 and arrive one count later.
                param_cs_c = (ld_cnt_q != 3'd5);
                ld_cnt_d   = ld_cnt_q + 3'd1;
                case (ld_cnt_q)
                    3'd1: r_d = bus.param_rdata[DIM_W-1:0];
                    3'd2: c_d = bus.param_rdata[DIM_W-1:0];
                    3'd3: k_d = bus.param_rdata[KW-1:0];
                    3'd4: s_d = bus.param_rdata[KW-1:0];
                    3'd5: begin
                        m_d     = bus.param_rdata[0];
                        state_d = CHECK;
                    end
                    default: ;
                endcase
            end
            CHECK: begin
                plane_d   = ADDR_W'(r_q) * ADDR_W'(r_q);
                kk_d      = (2*KW)'(k_q) * (2*KW)'(k_q);
                rd_cnt_d  = '0;
                ch_d      = '0;
                row0_d    = '0;
                col0_d    = '0;
                kr_d      = '0;
                kc_d      = '0;
                out_idx_d = '0;
                if (cfg_bad) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            READ: begin
                rd_cnt_d = rd_cnt_q + (2*KW)'(1);
                if (rd_cnt_q < kk_q) begin
                    in_cs_c = 1'b1;
                    if (kc_q == k_q - KW'(1)) begin
                        kc_d = '0;
                        kr_d = (kr_q == k_q - KW'(1)) ? '0 : kr_q + KW'(1);
                    end else begin
                        kc_d = kc_q + KW'(1);
                    end
                end
                if (rd_cnt_q == '0)
                    acc_d = m_q ? '0 : MOST_NEG;
                else if (m_q)
                    acc_d = acc_q + in_sext;
                else if (in_sext > acc_q)
                    acc_d = in_sext;
                if (rd_cnt_q == kk_q) begin
                    rd_cnt_d = '0;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                out_we_c  = 1'b1;
                out_idx_d = out_idx_q + ADDR_W'(1);
                state_d   = READ;
                if (!col_wrap) begin
                    col0_d = col0_q + DIM_W'(s_q);
                end else begin
                    col0_d = '0;
                    if (!row_wrap) begin
                        row0_d = row0_q + DIM_W'(s_q);
                    end else begin
                        row0_d = '0;
                        if (ch_q == c_q - DIM_W'(1))
                            state_d = DONE;
                        else
                            ch_d = ch_q + DIM_W'(1);
                    end
                end
            end
            DONE: begin
                if (!bus.start)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        finish_d = (state_d == DONE);
        if (state_d == IDLE)
            error_d = 1'b0;
    end

    // NOTE: asynchronous active-low reset; all state updates use non-blocking assignments.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ld_cnt_q  <= '0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            s_q       <= '0;
            m_q       <= 1'b0;
            plane_q   <= '0;
            kk_q      <= '0;
            rd_cnt_q  <= '0;
            ch_q      <= '0;
            row0_q    <= '0;
            col0_q    <= '0;
            kr_q      <= '0;
            kc_q      <= '0;
            acc_q     <= '0;
            out_idx_q <= '0;
            finish_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            s_q       <= s_d;
            m_q       <= m_d;
            plane_q   <= plane_d;
            kk_q      <= kk_d;
            rd_cnt_q  <= rd_cnt_d;
            ch_q      <= ch_d;
            row0_q    <= row0_d;
            col0_q    <= col0_d;
            kr_q      <= kr_d;
            kc_q      <= kc_d;
            acc_q     <= acc_d;
            out_idx_q <= out_idx_d;
            finish_q  <= finish_d;
            error_q   <= error_d;
        end
    end
endmodule

// File: tb/tb_pool_engine.sv
// Self-checking bench for pool_engine: SRAM models, directed layers and random layers
// compared against a loop-based pooling reference model.
module tb_pool_engine;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;
    localparam int MAX_K  = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pool_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    pool_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_K(MAX_K)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] param_mem [5];
    logic [7:0]  in_mem [4096];
    int wr_addr_q[$], wr_data_q[$], paddr_q[$];
    int exp_addr[$], exp_data[$];
    int oob_cnt = 0, bad_we_cnt = 0, lim = 0;
    int n_checks = 0, n_fail = 0;

    // Synchronous-read SRAM models and write monitor.
    always @(posedge clk) begin
        if (bus.param_cs) begin
            bus.param_rdata <= param_mem[bus.param_addr];
            paddr_q.push_back(int'(bus.param_addr));
        end
        if (bus.in_cs) begin
            if (int'(bus.in_addr) >= lim) oob_cnt++;
            bus.in_rdata <= in_mem[bus.in_addr[11:0]];
        end
        if (bus.out_we) begin
            if (!bus.out_cs) bad_we_cnt++;
            wr_addr_q.push_back(int'(bus.out_addr));
            wr_data_q.push_back(int'(bus.out_wdata));
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain nested loops over channels and output positions.
    function automatic bit model(input int r, input int c, input int k, input int s, input int m);
        int o, v, acc, n, q;
        exp_addr.delete();
        exp_data.delete();
        if (k == 0 || k > MAX_K || s == 0 || k > r || c == 0 ||
            (m == 1 && !(k == 1 || k == 2 || k == 4)))
            return 1'b1;
        o = (r - k) / s + 1;
        for (int ch = 0; ch < c; ch++)
            for (int orow = 0; orow < o; orow++)
                for (int ocol = 0; ocol < o; ocol++) begin
                    acc = (m == 1) ? 0 : -128;
                    for (int i = 0; i < k; i++)
                        for (int j = 0; j < k; j++) begin
                            v = $signed(in_mem[ch*r*r + (orow*s + i)*r + ocol*s + j]);
                            if (m == 1) acc += v;
                            else if (v > acc) acc = v;
                        end
                    if (m == 1) begin
                        n = k * k;
                        q = acc / n;
                        if ((acc % n) != 0 && acc < 0) q = q - 1;
                        acc = q;
                    end
                    exp_addr.push_back(ch*o*o + orow*o + ocol);
                    exp_data.push_back(acc & 255);
                end
        return 1'b0;
    endfunction

    task automatic run_layer(input int r, input int c, input int k, input int s,
                             input int m, input int hold);
        bit bad;
        int ecyc, n, o;
        param_mem[0] = r; param_mem[1] = c; param_mem[2] = k;
        param_mem[3] = s; param_mem[4] = m;
        lim = r * r * c;
        wr_addr_q.delete(); wr_data_q.delete(); paddr_q.delete();
        oob_cnt = 0; bad_we_cnt = 0;
        bad = model(r, c, k, s, m);
        o = bad ? 0 : (r - k) / s + 1;
        ecyc = 7 + c * o * o * (k * k + 2);
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (bus.finish !== 1'b1 && n < 20000) begin
            @(posedge clk); n++; #1;
        end
        check("cycles", n, ecyc);
        check("error", bus.error, bad);
        repeat (hold) @(posedge clk);
        #1;
        check("finish_held", bus.finish, 1);
        check("param_reads", paddr_q.size(), 5);
        check("param_first", (paddr_q.size() > 0) ? paddr_q[0] : -1, 0);
        @(negedge clk) bus.start = 1'b0;
        @(posedge clk); #1;
        check("finish_clr", bus.finish, 0);
        check("error_clr", bus.error, 0);
        check("n_writes", wr_addr_q.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
            check("wr_addr", wr_addr_q[i], exp_addr[i]);
            check("wr_data", wr_data_q[i], exp_data[i]);
        end
        check("in_range", oob_cnt, 0);
        check("we_with_cs", bad_we_cnt, 0);
    endtask

    function automatic int got_data(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : -1;
    endfunction

    initial begin
        int k035[4];
        int wsz;
        k035 = '{5, 7, 13, 15};
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.finish, bus.error, bus.param_cs, bus.in_cs,
                                bus.out_cs, bus.out_we}, 0);
        @(negedge clk) rstn = 1'b1;

        // Max pool 4x4 ramp, 2x2 stride 2.
        for (int i = 0; i < 16; i++) in_mem[i] = 8'(i);
        run_layer(4, 1, 2, 2, 0, 0);
        for (int i = 0; i < 4; i++) check("ramp_data", got_data(i), k035[i]);

        // Average pool: ch0 constant -3, ch1 windows {1,2,3,4}.
        for (int i = 0; i < 16; i++) in_mem[i] = 8'hFD;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                in_mem[16 + rr*4 + cc] = 8'(1 + (rr % 2) * 2 + (cc % 2));
        run_layer(4, 2, 2, 2, 1, 2);
        check("avg_neg", got_data(0), 253);
        check("avg_ch1", got_data(4), 2);
        check("avg_ch1_addr", (wr_addr_q.size() > 4) ? wr_addr_q[4] : -1, 4);

        // Max pool on extremes: only the last window holds 0x7F.
        for (int i = 0; i < 25; i++) in_mem[i] = 8'h80;
        in_mem[24] = 8'h7F;
        run_layer(5, 1, 3, 2, 0, 0);
        check("ext_first", got_data(0), 128);
        check("ext_last", got_data(3), 127);

        // Illegal configurations.
        run_layer(4, 1, 3, 1, 1, 0);
        run_layer(4, 1, 2, 0, 0, 1);
        run_layer(8, 1, 6, 1, 0, 0);

        // Reset pulsed mid-READ, then a clean rerun.
        for (int i = 0; i < 16; i++) in_mem[i] = 8'(i);
        param_mem[0] = 4; param_mem[1] = 1; param_mem[2] = 2;
        param_mem[3] = 2; param_mem[4] = 0;
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge clk) bus.start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        bus.start = 1'b0;
        #1;
        check("abort_outputs", {bus.finish, bus.error, bus.param_cs, bus.in_cs,
                                bus.out_cs, bus.out_we}, 0);
        wsz = wr_addr_q.size();
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_nowrite", wr_addr_q.size(), wsz);
        check("abort_idle", {bus.finish, bus.param_cs, bus.in_cs}, 0);
        run_layer(4, 1, 2, 2, 0, 3);
        for (int i = 0; i < 4; i++) check("rerun_data", got_data(i), k035[i]);

        // Random layers, legal and illegal.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 4096; i++) in_mem[i] = 8'($urandom);
            run_layer($urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(0, 5),
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_engine.md
POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed feature-map element width.
REQ-002 SHALL have parameter ADDR_W, default 32, SRAM address width.
REQ-003 SHALL have parameter MAX_K, default 4, largest supported square pooling kernel.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rstn, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, level request to run one layer.
REQ-007 SHALL have port finish, output, 1, layer done, registered.
REQ-008 SHALL have port error, output, 1, illegal configuration flag, registered.
REQ-009 SHALL have port param_cs, output, 1, parameter SRAM read enable.
REQ-010 SHALL have port param_addr, output, ADDR_W, parameter word address.
REQ-011 SHALL have port param_rdata, input, 32, parameter word, valid one cycle after cs.
REQ-012 SHALL have port in_cs, output, 1, input SRAM read enable.
REQ-013 SHALL have port in_addr, output, ADDR_W, input element address.
REQ-014 SHALL have port in_rdata, input, DATA_W, input element, valid one cycle after cs.
REQ-015 SHALL have port out_cs, output, 1, output SRAM enable.
REQ-016 SHALL have port out_we, output, 1, output write strobe.
REQ-017 SHALL have port out_addr, output, ADDR_W, output element address.
REQ-018 SHALL have port out_wdata, output, DATA_W, pooled result.

Function
REQ-019 SHALL run FSM IDLE -> LOAD -> CHECK -> READ <-> WRITE -> DONE -> IDLE.
REQ-020 SHALL leave IDLE on start=1; start SHALL be ignored in all other states.
REQ-021 LOAD SHALL read param words 0..4 on consecutive cycles: R (rows=cols), C (channels), K (kernel), S (stride), M (mode: 0 max, 1 avg); only low bits used; 6 cycles total.
REQ-022 CHECK (1 cycle) SHALL set error and go to DONE without writes if K=0, K>MAX_K, S=0, K>R, C=0, or M=1 with K not in {1,2,4}.
REQ-023 Output dimension SHALL be O = floor((R-K)/S)+1; total outputs C*O*O.
REQ-024 Input layout SHALL be addr = c*R*R + row*R + col; output addr SHALL be c*O*O + orow*O + ocol, iterating ocol fastest, then orow, then c.
REQ-025 READ SHALL issue K*K reads, one per cycle, window row-major from (orow*S, ocol*S), then one capture cycle: K*K+1 cycles.
REQ-026 WRITE SHALL last 1 cycle with out_cs=out_we=1 and stable out_addr/out_wdata; per-output latency K*K+2 cycles.
REQ-027 Max mode SHALL compare signed two's complement, initial value most-negative (0x80 for DATA_W=8).
REQ-028 Avg mode SHALL sum signed into an accumulator of DATA_W+2*ceil(log2(MAX_K)) bits, then arithmetic-shift right by log2(K*K) (floor toward minus infinity); no overflow possible.
REQ-029 After the last WRITE, FSM SHALL enter DONE; finish=1 from the next cycle while in DONE.
REQ-030 DONE SHALL return to IDLE when start=0; finish/error clear on the IDLE entry cycle.
REQ-031 cs strobes SHALL be 0 outside their states; out_we SHALL never be 1 outside WRITE.
REQ-032 Counters SHALL wrap cleanly: ocol->0 increments orow; orow->0 increments c; no address past R*R*C-1 SHALL be read.

Reset
REQ-033 rstn=0 SHALL force IDLE, all counters, addresses, config registers, accumulator 0, and finish, error, all cs/we 0, immediately and regardless of state.
REQ-034 Reset mid-layer SHALL abort without further writes; next start restarts from param word 0.

Verification
REQ-035 R=4,C=1,K=2,S=2,M=0, input 0..15 -> 4 writes, addr 0..3, data 5,7,13,15; finish after 6+1+4*6 cycles.
REQ-036 R=4,C=2,K=2,S=2,M=1, ch0 all -3, ch1 {1,2,3,4 per window} -> ch0 outputs -3, ch1 output 2 (10>>2), addr 4..7 for ch1.
REQ-037 R=5,K=3,S=2,M=0, all 0x80 except element 24=0x7F -> O=2, last output 0x7F, others 0x80.
REQ-038 K=3,M=1 or S=0 or K=6 -> error=1, finish=1, zero out_we pulses.
REQ-039 rstn pulsed mid-READ, then start -> no spurious write, full correct rerun; start held through DONE -> no second run until start drops.
